// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, response and ALU-side signals of alu_arbiter
// (suffixes are from the arbiter's point of view).
interface alu_arbiter_if;
    logic        req0_valid_i, req1_valid_i;
    logic        req0_ready_o, req1_ready_o;
    logic [2:0]  req0_ctrl_i, req1_ctrl_i;
    logic [31:0] req0_data1_i, req1_data1_i;
    logic [31:0] req0_data2_i, req1_data2_i;
    logic        rsp0_valid_o, rsp1_valid_o;
    logic        rsp0_ready_i, rsp1_ready_i;
    logic [31:0] rsp_data_o;
    logic        rsp_zero_o;
    logic [31:0] alu_data1_o, alu_data2_o;
    logic [2:0]  alu_ctrl_o;
    logic [31:0] alu_data_i;
    logic        alu_zero_i;
    modport slave (
        input  req0_valid_i, req1_valid_i, req0_ctrl_i, req1_ctrl_i,
        input  req0_data1_i, req1_data1_i, req0_data2_i, req1_data2_i,
        output req0_ready_o, req1_ready_o,
        output rsp0_valid_o, rsp1_valid_o, rsp_data_o, rsp_zero_o,
        input  rsp0_ready_i, rsp1_ready_i,
        output alu_data1_o, alu_data2_o, alu_ctrl_o,
        input  alu_data_i, alu_zero_i
    );
    modport master (
        output req0_valid_i, req1_valid_i, req0_ctrl_i, req1_ctrl_i,
        output req0_data1_i, req1_data1_i, req0_data2_i, req1_data2_i,
        input  req0_ready_o, req1_ready_o,
        input  rsp0_valid_o, rsp1_valid_o, rsp_data_o, rsp_zero_o,
        output rsp0_ready_i, rsp1_ready_i,
        input  alu_data1_o, alu_data2_o, alu_ctrl_o,
        output alu_data_i, alu_zero_i
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: serialises two requesters onto one shared ALU.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise req0 has fixed priority.
module alu_arbiter #(
    parameter int unsigned MUL_LAT = 3
) (
    input logic         clk_i,
    input logic         rst_i,
    alu_arbiter_if.slave bus
);
    localparam logic [2:0] ALUCTRL_MUL = 3'b011;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
    state_e      state_q, state_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] data1_q, data1_d, data2_q, data2_d, res_q, res_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        zero_q, zero_d, owner_q, owner_d, last_q, last_d;
    logic        grant, idle, rdy0, rdy1;
`ifdef ALU_ARB_RR_EN
    assign grant = (bus.req0_valid_i && bus.req1_valid_i) ? ~last_q : bus.req1_valid_i;
`else
    assign grant = ~bus.req0_valid_i;
`endif
    assign idle             = state_q == IDLE;
    assign rdy0             = idle && bus.req0_valid_i && !grant;
    assign rdy1             = idle && bus.req1_valid_i && grant;
    assign bus.req0_ready_o = rdy0;
    assign bus.req1_ready_o = rdy1;
    assign bus.rsp0_valid_o = state_q == RESP && !owner_q;
    assign bus.rsp1_valid_o = state_q == RESP && owner_q;
    assign bus.rsp_data_o   = res_q;
    assign bus.rsp_zero_o   = zero_q;
    assign bus.alu_data1_o  = data1_q;
    assign bus.alu_data2_o  = data2_q;
    assign bus.alu_ctrl_o   = ctrl_q;
    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        data1_d = data1_q;
        data2_d = data2_q;
        res_d   = res_q;
        zero_d  = zero_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (rdy0 || rdy1) begin
                ctrl_d  = grant ? bus.req1_ctrl_i : bus.req0_ctrl_i;
                data1_d = grant ? bus.req1_data1_i : bus.req0_data1_i;
                data2_d = grant ? bus.req1_data2_i : bus.req0_data2_i;
                owner_d = grant;
                cnt_d   = ctrl_d == ALUCTRL_MUL ? 4'(MUL_LAT - 1) : 4'd0;
                state_d = EXEC;
            end
            EXEC: if (cnt_q == 4'd0) begin
                res_d   = bus.alu_data_i;
                zero_d  = bus.alu_zero_i;
                state_d = RESP;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            RESP: if (owner_q ? bus.rsp1_ready_i : bus.rsp0_ready_i) begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
            data1_q <= '0;
            data2_q <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors plus arbitration and reset sequences for alu_arbiter.
module tb_alu_arbiter;
    localparam logic [2:0] C_AND = 3'b000, C_OR = 3'b001, C_ADD = 3'b010, C_MUL = 3'b011, C_SUB = 3'b110;
    typedef struct {
        logic        port;
        logic [2:0]  ctrl;
        logic [31:0] a, b, exp;
        logic        ezero;
        int          hold;
    } vec_t;
    logic clk = 1'b0, rst_n = 1'b0;
    int   errors = 0, checks = 0;
    always #5 clk = ~clk;
    alu_arbiter_if bus();
    alu_arbiter #(.MUL_LAT(3)) dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));
    always_comb begin
        case (bus.alu_ctrl_o)
            C_AND:   bus.alu_data_i = bus.alu_data1_o & bus.alu_data2_o;
            C_OR:    bus.alu_data_i = bus.alu_data1_o | bus.alu_data2_o;
            C_ADD:   bus.alu_data_i = bus.alu_data1_o + bus.alu_data2_o;
            C_SUB:   bus.alu_data_i = bus.alu_data1_o - bus.alu_data2_o;
            C_MUL:   bus.alu_data_i = bus.alu_data1_o * bus.alu_data2_o;
            default: bus.alu_data_i = bus.alu_data1_o ^ bus.alu_data2_o;
        endcase
    end
    assign bus.alu_zero_i = bus.alu_data_i == 32'd0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic set_req(input logic p, input logic v, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        if (p) begin
            bus.req1_valid_i = v; bus.req1_ctrl_i = c; bus.req1_data1_i = a; bus.req1_data2_i = b;
        end else begin
            bus.req0_valid_i = v; bus.req0_ctrl_i = c; bus.req0_data1_i = a; bus.req0_data2_i = b;
        end
    endtask
    task automatic run_op(input vec_t v);
        int lat;
        @(negedge clk);
        set_req(v.port, 1'b1, v.ctrl, v.a, v.b);
        #1;
        chk("req_ready", 32'(v.port ? bus.req1_ready_o : bus.req0_ready_o), 32'd1);
        chk("other_ready", 32'(v.port ? bus.req0_ready_o : bus.req1_ready_o), 32'd0);
        @(posedge clk);
        #1;
        set_req(v.port, 1'b0, 3'b000, 32'd0, 32'd0);
        lat = 0;
        while (!(v.port ? bus.rsp1_valid_o : bus.rsp0_valid_o) && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), v.ctrl == C_MUL ? 32'd3 : 32'd1);
        chk("rsp_data", bus.rsp_data_o, v.exp);
        chk("rsp_zero", 32'(bus.rsp_zero_o), 32'(v.ezero));
        chk("other_rsp_valid", 32'(v.port ? bus.rsp0_valid_o : bus.rsp1_valid_o), 32'd0);
        for (int i = 0; i < v.hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(v.port ? bus.rsp1_valid_o : bus.rsp0_valid_o), 32'd1);
            chk("hold_data", bus.rsp_data_o, v.exp);
        end
        if (v.port) bus.rsp1_ready_i = 1'b1; else bus.rsp0_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp0_ready_i = 1'b0;
        bus.rsp1_ready_i = 1'b0;
        chk("released", 32'(bus.rsp0_valid_o | bus.rsp1_valid_o), 32'd0);
    endtask
    task automatic check_zeroed(input string tag);
        chk({tag, "_rsp0_valid"}, 32'(bus.rsp0_valid_o), 32'd0);
        chk({tag, "_rsp1_valid"}, 32'(bus.rsp1_valid_o), 32'd0);
        chk({tag, "_rsp_data"}, bus.rsp_data_o, 32'd0);
        chk({tag, "_rsp_zero"}, 32'(bus.rsp_zero_o), 32'd0);
        chk({tag, "_alu_data1"}, bus.alu_data1_o, 32'd0);
        chk({tag, "_alu_data2"}, bus.alu_data2_o, 32'd0);
        chk({tag, "_alu_ctrl"}, 32'(bus.alu_ctrl_o), 32'd0);
        chk({tag, "_ready"}, 32'(bus.req0_ready_o | bus.req1_ready_o), 32'd0);
    endtask
    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask
    vec_t vecs[7];
    initial begin
        int grants[4], gt[4], n, cyc, multi, stray;
        vecs[0] = '{1'b0, C_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 0};
        vecs[1] = '{1'b1, C_SUB, 32'd9, 32'd9, 32'd0, 1'b1, 4};
        vecs[2] = '{1'b0, C_MUL, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 1'b0, 2};
        vecs[3] = '{1'b0, C_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 0};
        vecs[4] = '{1'b1, C_OR, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 1'b0, 1};
        vecs[5] = '{1'b1, C_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, 0};
        vecs[6] = '{1'b0, 3'b101, 32'h0000_AA55, 32'h0000_AA55, 32'd0, 1'b1, 0};
        set_req(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        set_req(1'b1, 1'b0, 3'b000, 32'd0, 32'd0);
        bus.rsp0_ready_i = 1'b0;
        bus.rsp1_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_zeroed("reset");
        foreach (vecs[i]) run_op(vecs[i]);
        // Both requesters stay valid with responses always accepted.
        pulse_reset();
        @(negedge clk);
        set_req(1'b0, 1'b1, C_ADD, 32'd1, 32'd2);
        set_req(1'b1, 1'b1, C_ADD, 32'd3, 32'd4);
        bus.rsp0_ready_i = 1'b1;
        bus.rsp1_ready_i = 1'b1;
        n = 0; cyc = 0; multi = 0;
        while (n < 4 && cyc < 60) begin
            @(negedge clk);
            if (bus.req0_ready_o && bus.req1_ready_o) multi++;
            if (bus.req0_ready_o || bus.req1_ready_o) begin
                grants[n] = int'(bus.req1_ready_o);
                gt[n] = cyc;
                n++;
            end
            cyc++;
        end
        set_req(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        set_req(1'b1, 1'b0, 3'b000, 32'd0, 32'd0);
        bus.rsp0_ready_i = 1'b0;
        bus.rsp1_ready_i = 1'b0;
        chk("arb_grant_count", 32'(n), 32'd4);
        chk("arb_single_ready", 32'(multi), 32'd0);
        for (int i = 0; i < n; i++) begin
`ifdef ALU_ARB_RR_EN
            chk("arb_grant", 32'(grants[i]), 32'(i % 2));
`else
            chk("arb_grant", 32'(grants[i]), 32'd0);
`endif
            if (i > 0) chk("arb_interval", 32'(gt[i] - gt[i-1]), 32'd3);
        end
        repeat (4) @(posedge clk);
        // Reset lands while a MUL is still executing.
        @(negedge clk);
        set_req(1'b0, 1'b1, C_MUL, 32'd6, 32'd7);
        @(posedge clk);
        #1;
        set_req(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        bus.rsp0_ready_i = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_zeroed("midexec");
        stray = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.rsp0_valid_o || bus.rsp1_valid_o) stray++;
        end
        bus.rsp0_ready_i = 1'b0;
        chk("midexec_no_rsp", 32'(stray), 32'd0);
        run_op('{1'b0, C_ADD, 32'd3, 32'd4, 32'd7, 1'b0, 0});
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
